id_ex_stage: RTL and testbench

ID/EX pipeline boundary of the 64-bit pipelined processor, directly downstream of the register file. It captures decoded operands, immediate, PC and control for the EX stage. It bypasses a same-cycle writeback into the captured operands and forces X31 (XZR) reads to zero. It also detects load-use hazards, asserting a stall to the front end and inserting a bubble; branch flush and back-end stall requests are handled here too.

---
 rtl/id_ex_stage.sv | 148 ++++++++++++++
 tb/tb_id_ex_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand select with WB bypass and XZR,
// load-use hazard detection, flush and back-end stall handling.
module id_ex_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IdValid,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  input  logic             UsesRs1,
  input  logic             UsesRs2,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic [4:0]       DstReg,
  input  logic [WIDTH-1:0] Imm,
  input  logic [WIDTH-1:0] PCIn,
  input  logic             RegWrite,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             MemToReg,
  input  logic             ALUSrc,
  input  logic             SetFlags,
  input  logic [2:0]       ALUOp,
  input  logic             WBRegWrite,
  input  logic [4:0]       WBWriteRegister,
  input  logic [WIDTH-1:0] WBWriteData,
  input  logic             Flush,
  input  logic             ExtStall,
  output logic             HazardStall,
  output logic             ExValid,
  output logic [WIDTH-1:0] ExReadData1,
  output logic [WIDTH-1:0] ExReadData2,
  output logic [WIDTH-1:0] ExImm,
  output logic [WIDTH-1:0] ExPC,
  output logic [4:0]       ExRs1,
  output logic [4:0]       ExRs2,
  output logic [4:0]       ExDstReg,
  output logic             ExRegWrite,
  output logic             ExMemRead,
  output logic             ExMemWrite,
  output logic             ExMemToReg,
  output logic             ExALUSrc,
  output logic             ExSetFlags,
  output logic [2:0]       ExALUOp
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       dst;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             alu_src;
    logic             set_flags;
    logic [2:0]       alu_op;
  } id_ex_t;

  id_ex_t ex_d;
  id_ex_t ex_q;

  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             hz;
  logic             dep1;
  logic             dep2;

  // Operand select: XZR reads as zero, then same-cycle WB bypass.
  always_comb begin
    op1 = ReadData1;
    op2 = ReadData2;
    if (ReadRegister1 == 5'd31)
      op1 = '0;
    else if (WBRegWrite && WBWriteRegister == ReadRegister1)
      op1 = WBWriteData;
    if (ReadRegister2 == 5'd31)
      op2 = '0;
    else if (WBRegWrite && WBWriteRegister == ReadRegister2)
      op2 = WBWriteData;
  end

  // Load-use detection against the instruction currently in EX.
  always_comb begin
    dep1 = UsesRs1 && (ex_q.dst == ReadRegister1);
    dep2 = UsesRs2 && (ex_q.dst == ReadRegister2);
    hz = IdValid && ex_q.valid && ex_q.mem_read &&
         (ex_q.dst != 5'd31) && (dep1 || dep2);
    HazardStall = hz && !Flush && !ExtStall;
  end

  // Next EX state: flush > hold > hazard bubble > capture.
  always_comb begin
    ex_d = '0;
    if (Flush) begin
      ex_d = '0;
    end else if (ExtStall) begin
      ex_d = ex_q;
    end else if (HazardStall) begin
      ex_d = '0;
    end else begin
      ex_d.valid      = IdValid;
      ex_d.rd1        = op1;
      ex_d.rd2        = op2;
      ex_d.imm        = Imm;
      ex_d.pc         = PCIn;
      ex_d.rs1        = ReadRegister1;
      ex_d.rs2        = ReadRegister2;
      ex_d.dst        = DstReg;
      ex_d.reg_write  = IdValid && RegWrite;
      ex_d.mem_read   = IdValid && MemRead;
      ex_d.mem_write  = IdValid && MemWrite;
      ex_d.mem_to_reg = IdValid && MemToReg;
      ex_d.alu_src    = IdValid && ALUSrc;
      ex_d.set_flags  = IdValid && SetFlags;
      ex_d.alu_op     = IdValid ? ALUOp : 3'd0;
    end
  end

  // Pipeline register, cleared to a bubble by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign ExValid     = ex_q.valid;
  assign ExReadData1 = ex_q.rd1;
  assign ExReadData2 = ex_q.rd2;
  assign ExImm       = ex_q.imm;
  assign ExPC        = ex_q.pc;
  assign ExRs1       = ex_q.rs1;
  assign ExRs2       = ex_q.rs2;
  assign ExDstReg    = ex_q.dst;
  assign ExRegWrite  = ex_q.reg_write;
  assign ExMemRead   = ex_q.mem_read;
  assign ExMemWrite  = ex_q.mem_write;
  assign ExMemToReg  = ex_q.mem_to_reg;
  assign ExALUSrc    = ex_q.alu_src;
  assign ExSetFlags  = ex_q.set_flags;
  assign ExALUOp     = ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, bypass, load-use,
// flush priority and back-end stall hold.
module tb_id_ex_stage;

  localparam int W = 64;

  logic         clk;
  logic         reset;
  logic         IdValid;
  logic [4:0]   ReadRegister1, ReadRegister2;
  logic         UsesRs1, UsesRs2;
  logic [W-1:0] ReadData1, ReadData2;
  logic [4:0]   DstReg;
  logic [W-1:0] Imm, PCIn;
  logic         RegWrite, MemRead, MemWrite, MemToReg;
  logic         ALUSrc, SetFlags;
  logic [2:0]   ALUOp;
  logic         WBRegWrite;
  logic [4:0]   WBWriteRegister;
  logic [W-1:0] WBWriteData;
  logic         Flush, ExtStall;
  logic         HazardStall, ExValid;
  logic [W-1:0] ExReadData1, ExReadData2, ExImm, ExPC;
  logic [4:0]   ExRs1, ExRs2, ExDstReg;
  logic         ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg;
  logic         ExALUSrc, ExSetFlags;
  logic [2:0]   ExALUOp;

  int total = 0;
  int bad = 0;

  id_ex_stage #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .IdValid(IdValid),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .UsesRs1(UsesRs1), .UsesRs2(UsesRs2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .DstReg(DstReg), .Imm(Imm), .PCIn(PCIn),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .ALUSrc(ALUSrc), .SetFlags(SetFlags),
    .ALUOp(ALUOp), .WBRegWrite(WBRegWrite),
    .WBWriteRegister(WBWriteRegister), .WBWriteData(WBWriteData),
    .Flush(Flush), .ExtStall(ExtStall), .HazardStall(HazardStall),
    .ExValid(ExValid), .ExReadData1(ExReadData1),
    .ExReadData2(ExReadData2), .ExImm(ExImm), .ExPC(ExPC),
    .ExRs1(ExRs1), .ExRs2(ExRs2), .ExDstReg(ExDstReg),
    .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
    .ExMemWrite(ExMemWrite), .ExMemToReg(ExMemToReg),
    .ExALUSrc(ExALUSrc), .ExSetFlags(ExSetFlags), .ExALUOp(ExALUOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IdValid = 0; ReadRegister1 = 0; ReadRegister2 = 0;
    UsesRs1 = 0; UsesRs2 = 0; ReadData1 = 0; ReadData2 = 0;
    DstReg = 0; Imm = 0; PCIn = 0; RegWrite = 0; MemRead = 0;
    MemWrite = 0; MemToReg = 0; ALUSrc = 0; SetFlags = 0;
    ALUOp = 0; WBRegWrite = 0; WBWriteRegister = 0;
    WBWriteData = 0; Flush = 0; ExtStall = 0;
  endtask

  task automatic ldur_x2();
    idle();
    IdValid = 1; MemRead = 1; MemToReg = 1; RegWrite = 1;
    DstReg = 2; ReadRegister1 = 1; UsesRs1 = 1;
    ReadRegister2 = 31; ALUSrc = 1; PCIn = 64'h300;
  endtask

  task automatic add_x4();
    idle();
    IdValid = 1; RegWrite = 1; DstReg = 4;
    ReadRegister1 = 2; ReadRegister2 = 3;
    UsesRs1 = 1; UsesRs2 = 1;
    ReadData1 = 64'h22; ReadData2 = 64'h33;
    PCIn = 64'h304; ALUOp = 3'd2;
  endtask

  initial begin
    reset = 0;
    idle();
    #3;
    chk("por_valid", ExValid, 0);
    chk("por_pc", ExPC, 0);
    #9 reset = 1;
    step();

    // Fill EX with nonzero state, then reset asynchronously.
    IdValid = 1; ReadRegister1 = 9; ReadRegister2 = 10;
    UsesRs1 = 1; UsesRs2 = 1; ReadData1 = 64'h91; ReadData2 = 64'h92;
    DstReg = 11; Imm = 64'h93; PCIn = 64'h94; RegWrite = 1;
    MemRead = 0; MemWrite = 1; MemToReg = 1; ALUSrc = 1;
    SetFlags = 1; ALUOp = 3'd7;
    step();
    chk("pre_rst_valid", ExValid, 1);
    chk("pre_rst_imm", ExImm, 64'h93);
    MemRead = 1; WBRegWrite = 1; WBWriteRegister = 12;
    WBWriteData = 64'h95; Flush = 1; ExtStall = 1;
    #2 reset = 0;
    #1;
    chk("rst_valid", ExValid, 0);
    chk("rst_rd1", ExReadData1, 0);
    chk("rst_imm", ExImm, 0);
    chk("rst_pc", ExPC, 0);
    chk("rst_dst", ExDstReg, 0);
    chk("rst_ctl", {ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg,
                    ExALUSrc, ExSetFlags, ExALUOp}, 0);
    chk("rst_hz", HazardStall, 0);
    idle();
    step();
    reset = 1;

    // Plain capture with XZR on source 2.
    IdValid = 1; ReadRegister1 = 3; ReadData1 = 64'h1234;
    ReadRegister2 = 31; ReadData2 = 64'hFFFF; Imm = 64'h10;
    RegWrite = 1; PCIn = 64'h100; DstReg = 1; ALUOp = 3'd3;
    step();
    chk("cap_rd1", ExReadData1, 64'h1234);
    chk("cap_rd2", ExReadData2, 0);
    chk("cap_imm", ExImm, 64'h10);
    chk("cap_rw", ExRegWrite, 1);
    chk("cap_valid", ExValid, 1);
    chk("cap_pc", ExPC, 64'h100);
    chk("cap_idx", {ExRs1, ExRs2, ExDstReg}, {5'd3, 5'd31, 5'd1});
    chk("cap_aluop", ExALUOp, 3);

    // Same-cycle WB bypass.
    idle();
    IdValid = 1; ReadRegister1 = 5; ReadData1 = 64'hAAAA;
    ReadRegister2 = 6; ReadData2 = 64'hBBBB;
    WBRegWrite = 1; WBWriteRegister = 5; WBWriteData = 64'h5555;
    step();
    chk("byp_rd1", ExReadData1, 64'h5555);
    chk("byp_rd2", ExReadData2, 64'hBBBB);
    WBRegWrite = 0;
    step();
    chk("nobyp_rd1", ExReadData1, 64'hAAAA);
    ReadRegister1 = 31; WBRegWrite = 1; WBWriteRegister = 31;
    step();
    chk("byp_xzr", ExReadData1, 0);

    // Load-use: exactly one bubble, then the ADD is captured.
    ldur_x2();
    step();
    chk("ld_memread", ExMemRead, 1);
    add_x4();
    #1;
    chk("lu_hz", HazardStall, 1);
    step();
    chk("lu_bub_valid", ExValid, 0);
    chk("lu_bub_rw", ExRegWrite, 0);
    chk("lu_bub_rd1", ExReadData1, 0);
    chk("lu_hz_gone", HazardStall, 0);
    step();
    chk("lu_add_valid", ExValid, 1);
    chk("lu_add_dst", ExDstReg, 4);
    chk("lu_add_rd1", ExReadData1, 64'h22);
    chk("lu_add_rw", ExRegWrite, 1);

    // Load followed by a non-consumer of X2.
    ldur_x2();
    step();
    add_x4();
    UsesRs1 = 0;
    #1;
    chk("nolu_hz", HazardStall, 0);
    step();
    chk("nolu_valid", ExValid, 1);
    chk("nolu_dst", ExDstReg, 4);

    // Flush beats a pending hazard.
    ldur_x2();
    step();
    add_x4();
    Flush = 1;
    #1;
    chk("fl_hz", HazardStall, 0);
    step();
    chk("fl_valid", ExValid, 0);
    chk("fl_pc", ExPC, 0);

    // ExtStall hold for 3 cycles while all inputs change.
    idle();
    IdValid = 1; ReadRegister1 = 6; ReadData1 = 64'h66;
    ReadRegister2 = 7; ReadData2 = 64'h77; Imm = 64'h70;
    PCIn = 64'h200; DstReg = 8; RegWrite = 1; ALUSrc = 1;
    SetFlags = 1; ALUOp = 3'd5;
    step();
    chk("hold_cap", ExReadData1, 64'h66);
    ExtStall = 1; ReadData1 = 64'h999; ReadData2 = 64'h888;
    ReadRegister2 = 9; Imm = 64'h71; PCIn = 64'h204; DstReg = 10;
    RegWrite = 0; MemWrite = 1; ALUSrc = 0; SetFlags = 0;
    ALUOp = 3'd1; WBRegWrite = 1; WBWriteRegister = 6;
    WBWriteData = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_rd1", ExReadData1, 64'h66);
      chk("hold_pc", ExPC, 64'h200);
      chk("hold_ctl", {ExValid, ExRegWrite, ExMemWrite, ExALUSrc,
                       ExSetFlags, ExDstReg, ExALUOp},
          {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 3'd5});
    end
    ExtStall = 0;
    step();
    chk("rel_rd1", ExReadData1, 64'hDEAD);
    chk("rel_rd2", ExReadData2, 64'h888);
    chk("rel_pc", ExPC, 64'h204);
    chk("rel_ctl", {ExRegWrite, ExMemWrite, ExDstReg, ExALUOp},
        {1'b0, 1'b1, 5'd10, 3'd1});

    // Flush together with ExtStall loads a bubble.
    Flush = 1; ExtStall = 1;
    step();
    chk("flst_valid", ExValid, 0);
    chk("flst_pc", ExPC, 0);
    chk("flst_mw", ExMemWrite, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
